// File: rtl/mem_lane_seq_pkg.sv
// Shared encodings for the Mem-stage lane sequencer: load/store types,
// Dcache access-width codes, sequencer states and width decode helpers.
package mem_lane_seq_pkg;

    localparam int LD_ENC_W = 3;
    localparam int ST_ENC_W = 2;

    localparam logic [2:0] LD_XXX = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LW  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    localparam logic [1:0] ST_XXX = 2'd0;
    localparam logic [1:0] ST_SB  = 2'd1;
    localparam logic [1:0] ST_SH  = 2'd2;
    localparam logic [1:0] ST_SW  = 2'd3;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    function automatic logic [1:0] ld_width(input logic [LD_ENC_W-1:0] t);
        logic [1:0] w;
        case (t)
            LD_LB, LD_LBU: w = W_BYTE;
            LD_LH, LD_LHU: w = W_HALF;
            default:       w = W_WORD;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] st_width(input logic [ST_ENC_W-1:0] t);
        logic [1:0] w;
        case (t)
            ST_SB:   w = W_BYTE;
            ST_SH:   w = W_HALF;
            default: w = W_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lane_pick.sv
// Lowest-set-bit picker: returns the winning bit as a one-hot vector and
// as a binary index, plus a flag that any request bit is set.
module lane_pick #(
    parameter int N    = 2,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    onehot_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = req_i & (~req_i + N'(1));
    assign any_o    = |req_i;

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDXW'(i);
        end
    end

endmodule

// File: rtl/mem_lane_seq.sv
// Serialises up to LANES load/store requests per cycle onto a single-port
// Dcache, lowest lane first, stalling the pipeline and buffering load data.
module mem_lane_seq
    import mem_lane_seq_pkg::*;
#(
    parameter int LANES         = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int LD_TYPE_WIDTH = 3,
    parameter int ST_TYPE_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LANES*LD_TYPE_WIDTH-1:0] ld_type,
    input  logic [LANES*ST_TYPE_WIDTH-1:0] st_type,
    input  logic [LANES*DATA_WIDTH-1:0]    alu_addr,
    input  logic [LANES*DATA_WIDTH-1:0]    rs2_data,
    input  logic                           csr_memflush,
    output logic [LANES-1:0]               ld_en,
    output logic                           mem_stall,
    output logic [LANES*DATA_WIDTH-1:0]    rdata,
    output logic                           dc_en,
    output logic                           dc_rd,
    output logic [1:0]                     dc_width,
    output logic                           dc_sign,
    output logic [ADDR_WIDTH-1:0]          dc_addr,
    output logic [DATA_WIDTH-1:0]          dc_wdata,
    input  logic                           dc_ready,
    input  logic [DATA_WIDTH-1:0]          dc_rdata,
    output logic                           dbg_state,
    output logic [LANES-1:0]               dbg_pend
);

    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

    state_e                             state_q, state_d;
    logic [LANES-1:0]                   pend_q, pend_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]   rbuf_q, rbuf_d;

    logic [LANES-1:0]                   lane_ld, lane_st, lane_sign, active;
    logic [LANES-1:0][1:0]              lane_width;
    logic [LANES-1:0][DATA_WIDTH-1:0]   addr_v, wdata_v, rdata_v;

    logic [LANES-1:0]                   cand, cur_oh, acc_oh, remain;
    logic [IDXW-1:0]                    cur_idx;
    logic                               cand_any, acc;

    assign addr_v  = alu_addr;
    assign wdata_v = rs2_data;
    assign rdata   = rdata_v;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LD_TYPE_WIDTH-1:0] lt;
        logic [ST_TYPE_WIDTH-1:0] stt;

        assign lt  = ld_type[g*LD_TYPE_WIDTH +: LD_TYPE_WIDTH];
        assign stt = st_type[g*ST_TYPE_WIDTH +: ST_TYPE_WIDTH];

        assign lane_ld[g]    = (lt != LD_TYPE_WIDTH'(LD_XXX));
        assign lane_st[g]    = (stt != ST_TYPE_WIDTH'(ST_XXX));
        // A flush squashes stores only; loads stay active.
        assign active[g]     = lane_ld[g] | (lane_st[g] & ~csr_memflush);
        assign lane_width[g] = lane_ld[g] ? ld_width(LD_ENC_W'(lt))
                                          : st_width(ST_ENC_W'(stt));
        assign lane_sign[g]  = lane_ld[g] & ((lt == LD_TYPE_WIDTH'(LD_LB)) |
                                             (lt == LD_TYPE_WIDTH'(LD_LH)));

        assign rdata_v[g] = acc_oh[g]           ? dc_rdata  :
                            (state_q == S_BUSY) ? rbuf_q[g] :
                            cur_oh[g]           ? dc_rdata  : '0;
    end

    assign ld_en = lane_ld;

    // A flush while busy empties the candidate set, so nothing issues.
    assign cand = (state_q == S_IDLE) ? active :
                  (csr_memflush ? '0 : pend_q);

    lane_pick #(.N(LANES), .IDXW(IDXW)) u_lane_pick (
        .req_i    (cand),
        .onehot_o (cur_oh),
        .idx_o    (cur_idx),
        .any_o    (cand_any)
    );

    assign acc       = cand_any & dc_ready;
    assign acc_oh    = cur_oh & {LANES{acc}};
    assign remain    = cand & ~acc_oh;
    assign mem_stall = |remain;

    always_comb begin
        dc_en    = cand_any;
        dc_rd    = 1'b0;
        dc_width = 2'b00;
        dc_sign  = 1'b0;
        dc_addr  = '0;
        dc_wdata = '0;
        if (cand_any) begin
            dc_rd    = lane_ld[cur_idx];
            dc_width = lane_width[cur_idx];
            dc_sign  = lane_sign[cur_idx];
            dc_addr  = addr_v[cur_idx][ADDR_WIDTH-1:0];
            dc_wdata = wdata_v[cur_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rbuf_d  = rbuf_q;
        if (acc && dc_rd) rbuf_d[cur_idx] = dc_rdata;
        if (state_q == S_IDLE) begin
            if (|remain) begin
                state_d = S_BUSY;
                pend_d  = remain;
            end
        end else begin
            pend_d = remain;
            if (csr_memflush || !(|remain)) begin
                state_d = S_IDLE;
                pend_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rbuf_q  <= rbuf_d;
        end
    end

    assign dbg_state = state_q;
    assign dbg_pend  = pend_q;

endmodule
